// File: rtl/nes_pkg.sv
// Shared definitions for the 2A03 sprite-DMA / CPU-bus arbiter.
//   dmaState_t    : controller states (IDLE, HALT, ALIGN, GET, PUT)
//   DMA_REG_ADDR  : CPU address whose write starts a sprite DMA
//   OAM_DATA_ADDR : PPU OAM data port that receives each byte
//   XFER_LEN      : bytes moved per DMA (one full page)
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    GET   = 3'd3,
    PUT   = 3'd4
  } dmaState_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          XFER_LEN      = 256;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite-DMA controller and CPU-bus arbiter.
// A CPU write to DMA_REG_ADDR halts the 6502 (ready low), then the block
// owns the system bus and copies page {page,00}..{page,FF} to OAM_DATA_ADDR
// as alternating get (read) / put (write) cycles before handing the bus back.
//
// Ports:
//   clock       in   CPU clock, rising edge
//   reset       in   synchronous, active-high
//   cpuAddr     in   address from the CPU core
//   cpuDataOut  in   CPU write data
//   cpuWrite    in   CPU write strobe (0 = read)
//   busDataIn   in   read data from the system bus
//   ready       out  to CPU ready input (0 halts the core)
//   busAddr     out  muxed system-bus address
//   busDataOut  out  muxed system-bus write data
//   busWrite    out  muxed system-bus write strobe
//   dmaActive   out  high while DMA drives the bus (ALIGN, GET, PUT)
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = nes_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_pkg::OAM_DATA_ADDR,
  parameter int          XFER_LEN      = nes_pkg::XFER_LEN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuWrite,
  input  logic [7:0]  busDataIn,
  output logic        ready,
  output logic [15:0] busAddr,
  output logic [7:0]  busDataOut,
  output logic        busWrite,
  output logic        dmaActive
);

  import nes_pkg::*;

  dmaState_t   r_state;
  dmaState_t   w_nextState;
  logic        r_parity;   // 0 = get slot, 1 = put slot
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  r_data;
  logic        w_trigger;

  assign w_trigger = cpuWrite && (cpuAddr == DMA_REG_ADDR);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_nextState = HALT;
      // The 6502 ignores ready during writes, so stay here until the first
      // read cycle. r_parity is the current slot; the following cycle has the
      // opposite parity, so a put-slot halt leads straight into a get slot.
      HALT:    if (!cpuWrite) w_nextState = r_parity ? GET : ALIGN;
      ALIGN:   w_nextState = GET;
      GET:     w_nextState = PUT;
      PUT:     w_nextState = (r_idx == 8'hFF) ? IDLE : GET;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_parity <= 1'b0;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_nextState;
      r_parity <= ~r_parity;
      if ((r_state == IDLE) && w_trigger) begin
        r_page <= cpuDataOut;
        r_idx  <= 8'h00;
      end
      if (r_state == GET) r_data <= busDataIn;
      // 8-bit wrap on the last put; the page never advances.
      if (r_state == PUT) r_idx <= r_idx + 8'd1;
    end
  end

  assign ready     = (r_state == IDLE);
  assign dmaActive = (r_state == ALIGN) || (r_state == GET) || (r_state == PUT);

  always_comb begin
    busAddr    = cpuAddr;
    busDataOut = cpuDataOut;
    busWrite   = cpuWrite;
    case (r_state)
      ALIGN: busWrite = 1'b0;
      GET: begin
        busAddr  = {r_page, r_idx};
        busWrite = 1'b0;
      end
      PUT: begin
        busAddr    = OAM_DATA_ADDR;
        busDataOut = r_data;
        busWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer length is tied to the 8-bit index; any other length is unsupported.
  always_ff @(posedge clock) begin
    assert (XFER_LEN == 256) else $error("oam_dma_arbiter: XFER_LEN must be 256");
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;
  localparam logic [1:0]  K_ALIGN = 2'd0, K_GET = 2'd1, K_PUT = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataOut;
  logic        cpuWrite;
  logic [7:0]  busDataIn;
  logic        ready;
  logic [15:0] busAddr;
  logic [7:0]  busDataOut;
  logic        busWrite;
  logic        dmaActive;

  oam_dma_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpuAddr    (cpuAddr),
    .cpuDataOut (cpuDataOut),
    .cpuWrite   (cpuWrite),
    .busDataIn  (busDataIn),
    .ready      (ready),
    .busAddr    (busAddr),
    .busDataOut (busDataOut),
    .busWrite   (busWrite),
    .dmaActive  (dmaActive)
  );

  always #5 clock = ~clock;

  // System memory contents as a fixed function of address.
  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [7:0] m;
    m = a[7:0] * 8'd13;
    return m ^ a[15:8] ^ 8'hA5;
  endfunction

  assign busDataIn = memf(busAddr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bus activity as a queue of slots.
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
  } slot_t;

  slot_t      q[$];
  int         mmode = 0;      // 0 CPU runs, 1 waiting for halt read, 2 transferring
  logic [7:0] mpage = 8'h00;
  logic       mpar  = 1'b0;   // parity of the current cycle
  bit         armed = 1'b0;

  // DUT-observed run statistics
  int          lowcnt = 0, putcnt = 0;
  int          lastRun = 0, lastPuts = 0;
  logic [15:0] prevAddr = 16'h0, firstGet = 16'h0, lastGet = 16'h0;
  logic [15:0] runFirst = 16'h0, runLast = 16'h0;

  initial begin
    forever begin
      @(negedge clock);
      if (armed) begin
        logic        eReady, eAct, eWr, chkDo;
        logic [15:0] eAddr;
        logic [7:0]  eDo;
        eReady = 1'b1; eAct = 1'b0; eWr = cpuWrite; eAddr = cpuAddr;
        eDo = cpuDataOut; chkDo = 1'b1;
        if (mmode == 1) eReady = 1'b0;
        if (mmode == 2) begin
          eReady = 1'b0;
          eAct   = 1'b1;
          case (q[0].kind)
            K_ALIGN: eWr = 1'b0;
            K_GET: begin eAddr = q[0].addr; eWr = 1'b0; chkDo = 1'b0; end
            default: begin eAddr = OAM; eWr = 1'b1; eDo = memf(q[0].addr); end
          endcase
        end
        chk("ready", ready, eReady);
        chk("dmaActive", dmaActive, eAct);
        chk("busWrite", busWrite, eWr);
        chk("busAddr", busAddr, eAddr);
        if (chkDo) chk("busDataOut", busDataOut, eDo);
      end
      if (!ready) begin
        lowcnt++;
        if (dmaActive && busWrite) begin
          if (putcnt == 0) firstGet = prevAddr;
          lastGet = prevAddr;
          putcnt++;
        end
      end else if (lowcnt != 0) begin
        lastRun = lowcnt; lastPuts = putcnt; runFirst = firstGet; runLast = lastGet;
        lowcnt = 0; putcnt = 0;
      end
      prevAddr = busAddr;

      @(posedge clock);
      if (reset) begin
        mmode = 0; q.delete(); mpar = 1'b0; armed = 1'b1;
      end else begin
        case (mmode)
          0: if (cpuWrite && cpuAddr == TRIG) begin mmode = 1; mpage = cpuDataOut; end
          1: if (!cpuWrite) begin
               // A halt in a get slot costs one dummy cycle to reach the next get slot.
               if (mpar == 1'b0) q.push_back('{kind: K_ALIGN, addr: 16'h0});
               for (int i = 0; i < 256; i++) begin
                 q.push_back('{kind: K_GET, addr: {mpage, 8'(i)}});
                 q.push_back('{kind: K_PUT, addr: {mpage, 8'(i)}});
               end
               mmode = 2;
             end
          default: begin
            void'(q.pop_front());
            if (q.size() == 0) mmode = 0;
          end
        endcase
        mpar = ~mpar;
      end
    end
  end

  task automatic step(input logic w, input logic [15:0] a, input logic [7:0] d);
    cpuWrite = w; cpuAddr = a; cpuDataOut = d;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rnd_wr_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == TRIG) a = a ^ 16'h0001;
    return a;
  endfunction

  task automatic align_to(input logic p);
    for (int k = 0; k < 4 && mpar != p; k++) step(1'b0, 16'h8000, 8'h00);
  endtask

  // Trigger at parity tp, nwr CPU writes, then stalled reads until done.
  // rstAt >= 0 pulses reset that many cycles into the wait.
  task automatic run_dma(input logic [7:0] page, input logic tp, input int nwr,
                         input int rstAt, input string name);
    int   expLow;
    logic hp;
    int   n;
    align_to(tp);
    step(1'b1, TRIG, page);
    for (int k = 0; k < nwr; k++) step(1'b1, rnd_wr_addr(), 8'($urandom));
    hp = tp ^ nwr[0] ^ 1'b1;
    expLow = nwr + 1 + (hp ? 0 : 1) + 512;
    n = 0;
    while (!ready && n < 3000) begin
      if (n == rstAt) begin
        reset = 1'b1;
        step(1'b0, 16'hC000, 8'h00);
        reset = 1'b0;
      end else begin
        step(1'b0, 16'hC000 | 16'($urandom_range(0, 255)), 8'h00);
      end
      n++;
    end
    chk({name, " finished"}, ready, 1);
    step(1'b0, 16'h8001, 8'h00);
    if (rstAt < 0) begin
      chk({name, " stall"}, lastRun, expLow);
      chk({name, " puts"}, lastPuts, 256);
      chk({name, " first get"}, runFirst, {page, 8'h00});
      chk({name, " last get"}, runLast, {page, 8'hFF});
    end
  endtask

  initial begin
    int found;
    reset = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0000; cpuDataOut = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    cpuAddr = 16'hABCD; cpuDataOut = 8'h3C; cpuWrite = 1'b1;
    #1;
    chk("reset ready", ready, 1);
    chk("reset dmaActive", dmaActive, 0);
    chk("reset busAddr", busAddr, 16'hABCD);
    chk("reset busDataOut", busDataOut, 8'h3C);
    chk("reset busWrite", busWrite, 1);
    step(1'b0, 16'h8000, 8'h00);

    // Idle: neighbouring register write and a read of the trigger address.
    step(1'b1, 16'h4015, 8'h02);
    step(1'b0, TRIG, 8'h00);
    step(1'b0, 16'h8000, 8'h00);
    chk("idle no dma ready", ready, 1);
    chk("idle no dma active", dmaActive, 0);

    run_dma(8'h02, 1'b0, 0, -1, "halt put slot");
    chk("no-align stall literal", lastRun, 513);
    run_dma(8'h02, 1'b1, 0, -1, "halt get slot");
    chk("align stall literal", lastRun, 514);
    run_dma(8'h05, 1'b0, 3, -1, "three writes");
    chk("three writes stall literal", lastRun, 517);
    run_dma(8'hFF, 1'b0, 0, -1, "page FF");
    chk("page FF last get literal", runLast, 16'hFFFF);
    chk("page FF back to cpu", ready, 1);

    // Reset in the middle of a transfer, at the get of index $40.
    align_to(1'b0);
    step(1'b1, TRIG, 8'h34);
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      if (dmaActive && !busWrite && busAddr == 16'h3440) found = 1;
      else step(1'b0, 16'h9000, 8'h00);
    end
    chk("reached idx 40", found, 1);
    reset = 1'b1;
    step(1'b0, 16'h1234, 8'h77);
    reset = 1'b0;
    chk("post-reset ready", ready, 1);
    chk("post-reset dmaActive", dmaActive, 0);
    chk("post-reset busAddr", busAddr, 16'h1234);
    chk("post-reset busDataOut", busDataOut, 8'h77);
    chk("post-reset busWrite", busWrite, 0);
    step(1'b0, 16'h8000, 8'h00);
    run_dma(8'h34, 1'b0, 0, -1, "restart after reset");

    // Randomized traffic and transfers.
    for (int r = 0; r < 8; r++) begin
      int idle_n;
      idle_n = $urandom_range(20, 100);
      for (int k = 0; k < idle_n; k++) begin
        logic w;
        w = ($urandom_range(0, 1) == 1);
        step(w, w ? rnd_wr_addr() : 16'($urandom), 8'($urandom));
      end
      run_dma(8'($urandom), 1'($urandom), $urandom_range(0, 3),
              (r % 3 == 2) ? $urandom_range(5, 500) : -1, "random dma");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
